// File: rtl/kong_pkg.sv
// Shared keypad definitions for the Kong player-input path.
// Key indices follow row*4 + col on the 4x4 matrix.
package kong_pkg;

  localparam int unsigned KEY_UP    = 1;
  localparam int unsigned KEY_LEFT  = 4;
  localparam int unsigned KEY_JUMP  = 5;
  localparam int unsigned KEY_RIGHT = 6;
  localparam int unsigned KEY_DOWN  = 9;

  typedef logic [15:0] keypad_bits;

endpackage

// File: rtl/kong_keypad_scanner.sv
// Column scanner for the 4x4 keypad: synchronizes rows, walks the columns and
// assembles a full-matrix snapshot, flagging the cycle on which a scan completes.
module kong_keypad_scanner
  import kong_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output keypad_bits snapshot,
  output logic       scan_done
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);

  logic [3:0]       row_meta_q, row_sync_q;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [1:0]       col_q, col_d;
  keypad_bits       snap_q, snap_d;
  logic             sample;

  always_ff @(posedge clk) begin
    if (resetN) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      slot_q     <= '0;
      col_q      <= '0;
      snap_q     <= '0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      slot_q     <= slot_d;
      col_q      <= col_d;
      snap_q     <= snap_d;
    end
  end

  always_comb begin
    sample = (slot_q == SlotLast);
    slot_d = sample ? '0 : slot_q + 1'b1;
    col_d  = sample ? col_q + 2'd1 : col_q;
    snap_d = snap_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        snap_d[r*4 + int'(col_q)] = ~row_sync_q[r];
      end
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  // The snapshot is presented with the final column already merged, so the
  // debouncer can compare the complete matrix on the sampling cycle itself.
  assign snapshot  = snap_d;
  assign scan_done = sample && (col_q == 2'd3);

endmodule

// File: rtl/kong_keypad.sv
// Keypad front end for Kong movement: debounces full-matrix scans, exposes
// direction levels, and turns each committed jump press into a one-frame request.
module kong_keypad
  import kong_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       ask_move_up,
  output logic       ask_move_down,
  output logic       ask_move_left,
  output logic       ask_move_right,
  output logic       ask_move_jump,
  output logic       any_key
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS);

  keypad_bits      snapshot;
  logic            scan_done;
  keypad_bits      prev_q, prev_d, stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            jump_prev_q, jump_edge;
  logic            pending_q, pending_d;
  logic            jump_q, jump_d;
  logic            up_q, down_q, left_q, right_q, any_q;

  kong_keypad_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scanner (
    .clk      (clk),
    .resetN   (resetN),
    .row_n    (row_n),
    .col_n    (col_n),
    .snapshot (snapshot),
    .scan_done(scan_done)
  );

  always_comb begin
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    if (scan_done) begin
      prev_d = snapshot;
      if (snapshot == prev_q) begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (cnt_d == CntMax) stable_d = snapshot;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // An edge coinciding with the frame pulse stays pending for the next frame.
  always_comb begin
    jump_edge = stable_q[KEY_JUMP] & ~jump_prev_q;
    pending_d = pending_q;
    jump_d    = jump_q;
    if (startOfFrame) begin
      jump_d    = pending_q;
      pending_d = jump_edge;
    end else if (jump_edge) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      prev_q      <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      jump_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      jump_q      <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      any_q       <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      jump_prev_q <= stable_q[KEY_JUMP];
      pending_q   <= pending_d;
      jump_q      <= jump_d;
      up_q        <= stable_q[KEY_UP];
      down_q      <= stable_q[KEY_DOWN];
      left_q      <= stable_q[KEY_LEFT];
      right_q     <= stable_q[KEY_RIGHT];
      any_q       <= |stable_q;
    end
  end

  assign ask_move_up    = up_q;
  assign ask_move_down  = down_q;
  assign ask_move_left  = left_q;
  assign ask_move_right = right_q;
  assign ask_move_jump  = jump_q;
  assign any_key        = any_q;

endmodule

// File: tb/tb_kong_keypad.sv
// Bench for kong_keypad with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scan).
// Expected {col_n, outputs} per cycle are queued up front and popped as the run reaches them.
module tb_kong_keypad;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       ask_move_up, ask_move_down, ask_move_left, ask_move_right;
  logic       ask_move_jump, any_key;
  logic [15:0] keys = '0;
  logic [5:0] outs;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    int         cyc;
    logic [3:0] col;
    logic [5:0] outs;
  } exp_t;
  exp_t sb[$];

  kong_keypad #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .row_n         (row_n),
    .col_n         (col_n),
    .ask_move_up   (ask_move_up),
    .ask_move_down (ask_move_down),
    .ask_move_left (ask_move_left),
    .ask_move_right(ask_move_right),
    .ask_move_jump (ask_move_jump),
    .any_key       (any_key)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle after the last edge that saw reset high.
  always @(posedge clk) begin
    if (resetN) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  assign outs = {any_key, ask_move_jump, ask_move_up, ask_move_down, ask_move_left,
                 ask_move_right};

  function automatic logic [3:0] exp_col(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((c / 4) % 4));
  endfunction

  task automatic push(input int c, input logic [5:0] o);
    exp_t e;
    e.cyc  = c;
    e.col  = exp_col(c);
    e.outs = o;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b0;
  endtask

  task automatic test_reset();
    int   guard;
    exp_t e;
    keys = '0;
    startOfFrame = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_col: got %b want 1110", col_n);
    end
    checks++;
    if (outs !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 000000", outs);
    end
    resetN = 1'b0;
    for (int k = 0; k < 20; k++) push(k, 6'b000000);
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({col_n, outs} !== {e.col, e.outs}) begin
          errors++;
          $display("FAIL reset_scan cyc=%0d: got %b/%b want %b/%b", cyc, col_n, outs, e.col,
                   e.outs);
        end
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL reset_scan timeout: %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_right_press();
    int   guard;
    exp_t e;
    keys = 16'h0040;
    startOfFrame = 1'b0;
    do_reset();
    push(48, 6'b000000);
    push(49, 6'b100001);
    push(112, 6'b100001);
    push(113, 6'b000000);
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({col_n, outs} !== {e.col, e.outs}) begin
          errors++;
          $display("FAIL right_press cyc=%0d: got %b/%b want %b/%b", cyc, col_n, outs, e.col,
                   e.outs);
        end
      end else begin
        @(negedge clk);
        guard++;
        if (cyc == 63) keys = '0;
      end
    end
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL right_press timeout: %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_bounce();
    int   guard;
    int   cnt_max;
    logic up_seen;
    exp_t e;
    keys = 16'h0002;
    startOfFrame = 1'b0;
    do_reset();
    cnt_max = 0;
    up_seen = 1'b0;
    for (int k = 1; k <= 10; k++) push(k * 16 + 1, 6'b000000);
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({col_n, outs} !== {e.col, e.outs}) begin
          errors++;
          $display("FAIL bounce cyc=%0d: got %b/%b want %b/%b", cyc, col_n, outs, e.col,
                   e.outs);
        end
      end else begin
        @(negedge clk);
        guard++;
        if (cyc % 16 == 15) keys[1] = ~keys[1];
        if (int'(dut.cnt_q) > cnt_max) cnt_max = int'(dut.cnt_q);
        up_seen = up_seen | ask_move_up;
      end
    end
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL bounce timeout: %0d pending, want 0", sb.size());
      sb.delete();
    end
    checks++;
    if (up_seen !== 1'b0) begin
      errors++;
      $display("FAIL bounce_up: got %b want 0", up_seen);
    end
    checks++;
    if (cnt_max != 0) begin
      errors++;
      $display("FAIL bounce_cnt: got max %0d want 0", cnt_max);
    end
    keys = '0;
  endtask

  task automatic test_jump();
    int   guard;
    int   high;
    int   rises;
    logic jprev;
    exp_t e;
    keys = 16'h0020;
    startOfFrame = 1'b0;
    do_reset();
    high  = 0;
    rises = 0;
    jprev = 1'b0;
    push(49, 6'b100000);
    push(60, 6'b100000);
    push(61, 6'b110000);
    push(160, 6'b110000);
    push(161, 6'b100000);
    push(300, 6'b000000);
    push(400, 6'b000000);
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({col_n, outs} !== {e.col, e.outs}) begin
          errors++;
          $display("FAIL jump cyc=%0d: got %b/%b want %b/%b", cyc, col_n, outs, e.col,
                   e.outs);
        end
      end else begin
        @(negedge clk);
        guard++;
        startOfFrame = (cyc % 100 == 60);
        if (cyc == 199) keys = '0;
        if (ask_move_jump === 1'b1) high++;
        if (ask_move_jump === 1'b1 && jprev === 1'b0) rises++;
        jprev = ask_move_jump;
      end
    end
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL jump timeout: %0d pending, want 0", sb.size());
      sb.delete();
    end
    startOfFrame = 1'b0;
    checks++;
    if (high != 100) begin
      errors++;
      $display("FAIL jump_width: got %0d cycles want 100", high);
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL jump_count: got %0d want 1", rises);
    end
  endtask

  task automatic test_jump_coincident();
    int   guard;
    exp_t e;
    keys = 16'h0020;
    startOfFrame = 1'b0;
    do_reset();
    push(48, 6'b000000);
    push(49, 6'b100000);
    push(148, 6'b000000);
    push(149, 6'b010000);
    push(248, 6'b010000);
    push(249, 6'b000000);
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({col_n, outs} !== {e.col, e.outs}) begin
          errors++;
          $display("FAIL jump_coincident cyc=%0d: got %b/%b want %b/%b", cyc, col_n, outs,
                   e.col, e.outs);
        end
      end else begin
        @(negedge clk);
        guard++;
        startOfFrame = (cyc % 100 == 48);
        if (cyc == 99) keys = '0;
      end
    end
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL jump_coincident timeout: %0d pending, want 0", sb.size());
      sb.delete();
    end
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int   guard;
    exp_t e;
    keys = 16'h0010;
    startOfFrame = 1'b0;
    do_reset();
    guard = 0;
    while (cyc != 41 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (int'(dut.cnt_q) != 1 || cyc != 41) begin
      errors++;
      $display("FAIL mid_precond: got cnt=%0d at cyc=%0d want cnt=1 at cyc=41",
               int'(dut.cnt_q), cyc);
    end
    resetN = 1'b1;
    @(negedge clk);
    resetN = 1'b0;
    checks++;
    if (col_n !== 4'b1110 || outs !== 6'b0) begin
      errors++;
      $display("FAIL mid_restart: got %b/%b want 1110/000000", col_n, outs);
    end
    push(20, 6'b000000);
    push(48, 6'b000000);
    push(49, 6'b100010);
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      if (sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if ({col_n, outs} !== {e.col, e.outs}) begin
          errors++;
          $display("FAIL mid_rescan cyc=%0d: got %b/%b want %b/%b", cyc, col_n, outs, e.col,
                   e.outs);
        end
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL mid_rescan timeout: %0d pending, want 0", sb.size());
      sb.delete();
    end
    keys = '0;
  endtask

  initial begin
    test_reset();
    test_right_press();
    test_bounce();
    test_jump();
    test_jump_coincident();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kong_keypad.md
# kong_keypad

Scans the 4x4 matrix keypad and produces debounced player requests for the Kong movement logic. The block sits directly upstream of that logic and drives its ask_move_right, ask_move_left, ask_move_up, ask_move_down and ask_move_jump inputs. Direction requests are debounced levels. Jump is delivered as a single-frame request aligned to startOfFrame, so one physical press produces exactly one jump.

## Interface
Parameters:
- SCAN_DIV, default 1000: clock cycles per column slot. Must be ≥ 4.
- DEBOUNCE_SCANS, default 4: consecutive equal full-scan comparisons required before a snapshot is committed. Must be ≥ 1.

Ports:
- clk, input, 1: system clock.
- resetN, input, 1: one clock; reset is synchronous and active-high. The port keeps the top-level name.
- startOfFrame, input, 1: one-cycle frame pulse, shared with the movement logic.
- row_n, input, 4: keypad rows, active-low, asynchronous.
- col_n, output, 4: keypad column drive, one-cold.
- ask_move_up / ask_move_down / ask_move_left / ask_move_right, output, 1 each: debounced key levels.
- ask_move_jump, output, 1: jump request, high for exactly one frame.
- any_key, output, 1: OR of all 16 committed keys.

## Operation
- **Key layout.** Index = row*4 + col. Map: up = 1 ('2'), left = 4 ('4'), jump = 5 ('5'), right = 6 ('6'), down = 9 ('8').
- **Row synchronizer.** row_n passes through a 2-FF synchronizer before use.
- **Scan sequencer.**
  - slot counter runs 0..SCAN_DIV-1 for each column index 0..3.
  - col_n drives column c low and all others high.
  - At slot == SCAN_DIV-1, the synchronized inverted rows are written into snapshot bits {r*4+c}. The column then advances, wrapping 3→0.
- **Scan end.** A scan ends on the sample of column 3. At that point the complete snapshot is compared against prev_snapshot:
  - Equal: cnt increments, saturating at DEBOUNCE_SCANS. When cnt reaches DEBOUNCE_SCANS, stable_keys ← snapshot.
  - Different: cnt ← 0.
  - In both cases prev_snapshot ← snapshot.
- **Direction outputs.** Registered copies of the stable_keys bits. No up/down or left/right arbitration is done here; the movement logic arbitrates.
- **Jump pending.** A rising edge of stable_keys[5] sets jump_pending. The edge is detected against a registered copy of that bit.
- **Jump output.** On startOfFrame: ask_move_jump ← jump_pending, and jump_pending ← 0.
  - If an edge and startOfFrame fall on the same cycle, jump_pending stays set and the jump is emitted on the next startOfFrame.
  - Holding the key produces no repeat jump. A new press requires a committed release followed by a committed press.
- **any_key.** Registered OR of stable_keys.

## Timing
- **Reset values:** col_n = 4'b1110, column 0, slot 0, snapshot/prev_snapshot/stable_keys = 0, cnt = 0, jump_pending = 0, every output 0.
- **Reset mid-scan:** the partial snapshot is discarded and scanning restarts at column 0.
- **Full scan:** 4*SCAN_DIV cycles.
- **Press latency:**
  - A key held from the start of a scan is committed at the end of scan DEBOUNCE_SCANS+1, counting that first scan as scan 1.
  - Direction outputs follow the commit by 1 cycle.
  - ask_move_jump rises on the first startOfFrame after jump_pending sets, and falls on the following startOfFrame.
- **Release latency:** the same as press latency.
- **Bounce:** any change of the snapshot within the window restarts the count, so a key toggling every scan is never committed.
- **Sampling margin:** the column is driven low for SCAN_DIV-1 cycles before its sample. The synchronizer adds 2 cycles.

## Structure
- **kong_pkg additions:**
  - KEY_UP = 1, KEY_LEFT = 4, KEY_JUMP = 5, KEY_RIGHT = 6, KEY_DOWN = 9.
  - typedef keypad_bits (logic [15:0]).
- **Sub-module kong_keypad_scanner.** Contains the synchronizer, slot/column counters and snapshot assembly. It outputs snapshot plus a one-cycle scan_done.
- **Top level.** Holds the debounce counter, stable_keys, the jump edge/pending logic and the output registers.

## Test plan
Simulation parameters are SCAN_DIV = 4 and DEBOUNCE_SCANS = 2, giving a 16-cycle scan.

- **Reset:** reset held 3 cycles, then released. Required: col_n = 1110 → 1101 → 1011 → 0111, each held 4 cycles, then wrapping to 1110. All outputs 0.
- **Right press:** row1 low whenever col2 is driven, steady from a scan boundary. Required: ask_move_right = 1 one cycle after the end of scan 3 (cycle 48 + 1). Releasing returns it to 0 after the same 3 scans.
- **Bounce:** key '2' (row0, col1) present on alternate scans for 10 scans. Required: ask_move_up stays 0 and cnt never exceeds 0.
- **Jump timing:** startOfFrame every 100 cycles; key '5' held 200 cycles. Required: ask_move_jump high from the first startOfFrame after the commit, for exactly 100 cycles, and only once.
- **Jump coincident with frame:** the jump commit edge lands on the same cycle as startOfFrame. Required: ask_move_jump rises at the next startOfFrame, not the current one.
- **Reset mid-scan:** reset asserted during a column 2 slot while key '4' is half-debounced (cnt = 1). Required: after reset, ask_move_left needs the full 3 scans again.
